// File: rtl/mulcpu_datapath.sv
// mulcpu_datapath: multicycle MIPS-subset datapath (PC/IR/DR/A/B/C, 32x32 regfile, ALU); `MULCPU_DATAPATH_DEBUG_EN adds a regfile debug read port
module mulcpu_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_pc,
    input  logic        write_ir,
    input  logic        write_dr,
    input  logic        write_a,
    input  logic        write_b,
    input  logic        write_c,
    input  logic        write_reg,
    input  logic        write_mem,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  pcsource,
    input  logic [1:0]  alu_ctrl,
    input  logic        alu_srcA,
    input  logic [1:0]  alu_srcB,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_data,
    output logic        zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] pc_out
`ifdef MULCPU_DATAPATH_DEBUG_EN
    ,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
`endif
);
    logic [31:0] pc_q, pc_d, ir_q, ir_d, dr_q, dr_d, a_q, a_d, b_q, b_d, c_q, c_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic [31:0] sext, alu_a, alu_b, alu_y, jump_tgt, wr_data;
    logic [4:0]  wr_idx;

    always_comb begin
        sext     = {{16{ir_q[15]}}, ir_q[15:0]};
        alu_a    = alu_srcA ? a_q : pc_q;
        alu_b    = alu_srcB == 2'b00 ? b_q :
                   alu_srcB == 2'b01 ? 32'd4 :
                   alu_srcB == 2'b10 ? sext : {sext[29:0], 2'b00};
        alu_y    = alu_ctrl == 2'b00 ? alu_a + alu_b :
                   alu_ctrl == 2'b01 ? alu_a - alu_b :
                   alu_ctrl == 2'b11 ? alu_a & alu_b :
                   {31'd0, $signed(alu_a) < $signed(alu_b)};
        jump_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};
        pc_d     = !write_pc ? pc_q :
                   pcsource == 2'b00 ? alu_y :
                   pcsource == 2'b01 ? c_q :
                   pcsource == 2'b10 ? jump_tgt : pc_q;
        ir_d     = write_ir ? mem_rdata : ir_q;
        dr_d     = write_dr ? mem_rdata : dr_q;
        a_d      = write_a ? rf_q[ir_q[25:21]] : a_q;
        b_d      = write_b ? rf_q[ir_q[20:16]] : b_q;
        c_d      = write_c ? alu_y : c_q;
        wr_idx   = regdst ? ir_q[15:11] : ir_q[20:16];
        wr_data  = memtoreg ? dr_q : c_q;
        // entry 0 is never written, so it stays at its reset value of zero
        for (int i = 0; i < 32; i++)
            rf_d[i] = (write_reg && i != 0 && wr_idx == 5'(i)) ? wr_data : rf_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            ir_q <= '0;
            dr_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            dr_q <= dr_d;
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= rf_d[i];
        end
    end

    assign ir_data   = ir_q;
    assign zero      = alu_y == 32'd0;
    assign mem_addr  = iord ? c_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = write_mem;
    assign pc_out    = pc_q;
`ifdef MULCPU_DATAPATH_DEBUG_EN
    assign dbg_data  = rf_q[dbg_sel];
`endif
endmodule
